// File: rtl/router_pkg.sv
// Shared constants and types for the 5-port wormhole router.
// Port index order: local, north, south, east, west.
package router_pkg;

  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } dir_e;

  typedef logic [2:0] port_t;

endpackage

// File: rtl/router_fifo.sv
// Synchronous per-input flit buffer.
// A push is refused while full, even when a pop happens the same cycle.
module router_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == DEPTH_C;
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/wormhole_router.sv
// 5-port input-buffered wormhole router, XY routing, per-output RR locks.
// Define ROUTER_DROP_CNT_EN to add saturating per-input drop counters.
module wormhole_router
  import router_pkg::*;
#(
  parameter int FLIT_W        = 4,
  parameter int FLITS_PER_PKT = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int X_COORDINATE  = 1,
  parameter int Y_COORDINATE  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]        write_en,
  output logic [NUM_PORTS-1:0]        full,
  output logic [NUM_PORTS*FLIT_W-1:0] out_flit,
  output logic [NUM_PORTS-1:0]        write_req,
`ifdef ROUTER_DROP_CNT_EN
  output logic [NUM_PORTS*16-1:0]     drop_count,
`endif
  input  logic [NUM_PORTS-1:0]        dest_full
);
  localparam int HW = FLIT_W / 2;
  localparam int CW = $clog2(FLITS_PER_PKT);
  localparam logic [CW-1:0] LAST = CW'(FLITS_PER_PKT - 1);
  localparam logic [HW-1:0] MY_X = HW'(X_COORDINATE);
  localparam logic [HW-1:0] MY_Y = HW'(Y_COORDINATE);

  logic [FLIT_W-1:0]    front [NUM_PORTS];
  logic [HW-1:0]        dx [NUM_PORTS];
  logic [HW-1:0]        dy [NUM_PORTS];
  dir_e                 route [NUM_PORTS];
  logic [NUM_PORTS-1:0] req [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty, pop, gnt_v, fwd;
  port_t                gnt_in [NUM_PORTS];
  port_t                src [NUM_PORTS];
  port_t                ptr_q [NUM_PORTS], ptr_d [NUM_PORTS];
  port_t                lock_in_q [NUM_PORTS], lock_in_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] lock_v_q, lock_v_d;
  logic [CW-1:0]        cnt_q [NUM_PORTS], cnt_d [NUM_PORTS];
  logic [FLIT_W-1:0]    out_q [NUM_PORTS], out_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] wreq_q, wreq_d;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_fifo #(
      .W     (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (write_en[i]),
      .pop_i   (pop[i]),
      .din_i   (in_flit[i*FLIT_W +: FLIT_W]),
      .dout_o  (front[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
    assign out_flit[i*FLIT_W +: FLIT_W] = out_q[i];
  end

  assign write_req = wreq_q;

  // XY route of whatever sits at each FIFO front; only heads use it
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dx[i] = front[i][HW-1:0];
      dy[i] = front[i][FLIT_W-1:HW];
      route[i] = LOCAL;
      if (dx[i] > MY_X)      route[i] = EAST;
      else if (dx[i] < MY_X) route[i] = WEST;
      else if (dy[i] > MY_Y) route[i] = NORTH;
      else if (dy[i] < MY_Y) route[i] = SOUTH;
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = !empty[i] && cnt_q[i] == '0
                    && route[i] == dir_e'(o);
      end
      gnt_v[o]  = 1'b0;
      gnt_in[o] = '0;
      ptr_d[o]  = ptr_q[o];
      if (!lock_v_q[o] && !dest_full[o]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = (int'(ptr_q[o]) + k) % NUM_PORTS;
          if (!gnt_v[o] && req[o][idx]) begin
            gnt_v[o]  = 1'b1;
            gnt_in[o] = port_t'(idx);
            ptr_d[o]  = port_t'((idx + 1) % NUM_PORTS);
          end
        end
      end
      src[o] = lock_v_q[o] ? lock_in_q[o] : gnt_in[o];
      fwd[o] = !dest_full[o]
               && (lock_v_q[o] ? !empty[src[o]] : gnt_v[o]);
    end
  end

  // Head pops on its grant cycle; the tail pop frees the lock
  always_comb begin
    pop      = '0;
    lock_v_d = lock_v_q;
    wreq_d   = fwd;
    for (int o = 0; o < NUM_PORTS; o++) begin
      lock_in_d[o] = lock_in_q[o];
      out_d[o]     = out_q[o];
      if (gnt_v[o]) begin
        lock_v_d[o]  = 1'b1;
        lock_in_d[o] = gnt_in[o];
      end
      if (fwd[o]) begin
        pop[src[o]] = 1'b1;
        out_d[o]    = front[src[o]];
        if (cnt_q[src[o]] == LAST) lock_v_d[o] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pop[i]) cnt_d[i] = (cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_v_q <= '0;
      wreq_q   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        ptr_q[i]     <= '0;
        lock_in_q[i] <= '0;
        cnt_q[i]     <= '0;
        out_q[i]     <= '0;
      end
    end else begin
      lock_v_q <= lock_v_d;
      wreq_q   <= wreq_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        ptr_q[i]     <= ptr_d[i];
        lock_in_q[i] <= lock_in_d[i];
        cnt_q[i]     <= cnt_d[i];
        out_q[i]     <= out_d[i];
      end
    end
  end

`ifdef ROUTER_DROP_CNT_EN
  logic [15:0] drop_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (write_en[i] && full[i] && drop_q[i] != 16'hFFFF)
          drop_q[i] <= drop_q[i] + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_drop
    assign drop_count[i*16 +: 16] = drop_q[i];
  end
`endif

endmodule

// File: tb/tb_wormhole_router.sv
// Bench for wormhole_router: queue-level reference model checked every
// cycle, plus directed packet scenarios with literal expectations.
`timescale 1ns/1ps
module tb_wormhole_router;
  localparam int FW    = 4;
  localparam int FPP   = 8;
  localparam int DEPTH = 4;
  localparam int NP    = 5;
  localparam int MX    = 1;
  localparam int MY    = 1;

  typedef struct {
    int         c;
    int         o;
    logic [3:0] f;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP*FW-1:0] in_flit;
  logic [NP-1:0]   write_en;
  logic [NP-1:0]   full;
  logic [NP*FW-1:0] out_flit;
  logic [NP-1:0]   write_req;
  logic [NP-1:0]   dest_full;
`ifdef ROUTER_DROP_CNT_EN
  logic [NP*16-1:0] drop_count;
`endif

  always #5 clk = ~clk;

  wormhole_router #(
    .FLIT_W        (FW),
    .FLITS_PER_PKT (FPP),
    .FIFO_DEPTH    (DEPTH),
    .X_COORDINATE  (MX),
    .Y_COORDINATE  (MY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_flit    (in_flit),
    .write_en   (write_en),
    .full       (full),
    .out_flit   (out_flit),
    .write_req  (write_req),
`ifdef ROUTER_DROP_CNT_EN
    .drop_count (drop_count),
`endif
    .dest_full  (dest_full)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [3:0]  mq [NP][$];
  int          mown [NP];
  int          mptr [NP];
  int          mcnt [NP];
  int          mdrop [NP];
  logic [NP-1:0] exp_req;
  logic [3:0]  exp_flit [NP];

  logic [3:0]  pend [NP][$];
  logic [3:0]  pkt [6][FPP];
  ent_t        olog [$];
  ent_t        sel [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int route_of(input logic [3:0] h);
    int dx, dy;
    dx = int'(h[1:0]);
    dy = int'(h[3:2]);
    if (dx > MX) return 3;
    if (dx < MX) return 4;
    if (dy > MY) return 1;
    if (dy < MY) return 2;
    return 0;
  endfunction

  task automatic model_step();
    bit fpre [NP];
    bit used [NP];
    int s, i;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      fpre[p] = (mq[p].size() == DEPTH);
      used[p] = 1'b0;
    end
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        mown[p] = -1;
        mptr[p] = 0;
        mcnt[p] = 0;
        mdrop[p] = 0;
        exp_req[p] = 1'b0;
        exp_flit[p] = '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        s = -1;
        exp_req[o] = 1'b0;
        if (mown[o] >= 0) begin
          if (mq[mown[o]].size() > 0 && !dest_full[o]) s = mown[o];
        end else if (!dest_full[o]) begin
          for (int k = 0; k < NP; k++) begin
            i = (mptr[o] + k) % NP;
            if (s < 0 && !used[i] && mq[i].size() > 0 && mcnt[i] == 0
                && route_of(mq[i][0]) == o) begin
              s = i;
              mown[o] = i;
              mptr[o] = (i + 1) % NP;
            end
          end
        end
        if (s >= 0) begin
          used[s] = 1'b1;
          exp_req[o] = 1'b1;
          exp_flit[o] = mq[s].pop_front();
          mcnt[s]++;
          if (mcnt[s] == FPP) begin
            mcnt[s] = 0;
            mown[o] = -1;
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (write_en[p]) begin
          if (fpre[p]) begin
            if (mdrop[p] < 65535) mdrop[p]++;
          end else begin
            mq[p].push_back(in_flit[p*FW +: FW]);
          end
        end
      end
    end
  endtask

  task automatic monitor();
    ent_t e;
    for (int o = 0; o < NP; o++) begin
      chk($sformatf("write_req[%0d]", o), write_req[o], exp_req[o]);
      if (exp_req[o])
        chk($sformatf("out_flit[%0d]", o), out_flit[o*FW +: FW], exp_flit[o]);
      if (write_req[o] === 1'b1) begin
        e.c = cyc;
        e.o = o;
        e.f = out_flit[o*FW +: FW];
        olog.push_back(e);
      end
    end
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("full[%0d]", p), full[p], mq[p].size() == DEPTH);
`ifdef ROUTER_DROP_CNT_EN
      chk($sformatf("drop_count[%0d]", p), drop_count[p*16 +: 16], mdrop[p]);
`endif
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) monitor();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int id, input logic [3:0] head,
                         input logic [3:0] base);
    pkt[id][0] = head;
    for (int k = 1; k < FPP; k++) pkt[id][k] = base + 4'(k);
  endtask

  task automatic load(input int p, input int id);
    for (int k = 0; k < FPP; k++) pend[p].push_back(pkt[id][k]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    write_en = '0;
    dest_full = '0;
    for (int p = 0; p < NP; p++) pend[p].delete();
    step();
    reset = 1'b0;
    olog.delete();
  endtask

  task automatic run(input int n, input int dfp, input int dfs,
                     input int dfl, output int w0);
    w0 = cyc;
    for (int j = 0; j < n; j++) begin
      dest_full = '0;
      if (dfp >= 0 && j >= dfs && j < dfs + dfl) dest_full[dfp] = 1'b1;
      write_en = '0;
      for (int p = 0; p < NP; p++) begin
        if (pend[p].size() > 0 && !full[p]) begin
          write_en[p] = 1'b1;
          in_flit[p*FW +: FW] = pend[p].pop_front();
        end
      end
      step();
    end
    write_en = '0;
    dest_full = '0;
  endtask

  task automatic select_out(input int o);
    sel.delete();
    foreach (olog[k]) if (olog[k].o == o) sel.push_back(olog[k]);
  endtask

  task automatic expect_pkts(input string nm, input int o, input int ida,
                             input int idb, input int c0);
    int n;
    logic [3:0] e;
    n = (idb >= 0) ? 2 * FPP : FPP;
    select_out(o);
    chk({nm, "_count"}, sel.size(), n);
    for (int k = 0; k < n && k < sel.size(); k++) begin
      e = (k < FPP) ? pkt[ida][k] : pkt[idb][k-FPP];
      chk($sformatf("%s_flit%0d", nm, k), sel[k].f, e);
      if (c0 >= 0) chk($sformatf("%s_cyc%0d", nm, k), sel[k].c, c0 + k);
    end
  endtask

  int  w0;
  logic fl [6];

  initial begin
    set_pkt(0, 4'h7, 4'h0);
    set_pkt(1, 4'h7, 4'h8);
    set_pkt(2, 4'h9, 4'h3);
    set_pkt(3, 4'h5, 4'h8);
    set_pkt(4, 4'h1, 4'h3);
    set_pkt(5, 4'h2, 4'h8);
    reset = 1'b1;
    write_en = '0;
    in_flit = '0;
    dest_full = '0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_write_req", write_req, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_full", full, 0);
    chk_en = 1'b1;
    step();

    // local head (3,1) -> east, 8 flits, 2-cycle latency
    do_reset();
    load(0, 0);
    run(14, -1, 0, 0, w0);
    expect_pkts("t1_east", 3, 0, -1, w0 + 2);
    chk("t1_total", olog.size(), FPP);

    // north and west both to east: north first, no interleave
    do_reset();
    load(1, 0);
    load(4, 1);
    run(24, -1, 0, 0, w0);
    expect_pkts("t2_east", 3, 0, 1, w0 + 2);
    chk("t2_total", olog.size(), 2 * FPP);

    // east blocked 3 cycles after flit 3, south head waits
    do_reset();
    load(0, 0);
    load(2, 5);
    run(30, 3, 5, 3, w0);
    expect_pkts("t3_east", 3, 0, 5, -1);
    select_out(3);
    if (sel.size() >= 9) begin
      chk("t3_flit3_cyc", sel[3].c, w0 + 5);
      chk("t3_flit4_cyc", sel[4].c, w0 + 9);
      chk("t3_tail_cyc", sel[7].c, w0 + 12);
      chk("t3_next_head_cyc", sel[8].c, w0 + 13);
    end

    // 6 forced writes with east blocked: 2 drops
    do_reset();
    for (int j = 0; j < 6; j++) begin
      write_en = 5'b00001;
      in_flit[3:0] = pkt[0][j];
      dest_full = 5'b01000;
      step();
      fl[j] = full[0];
    end
    for (int j = 0; j < 6; j++)
      chk($sformatf("t4_full_after_w%0d", j + 1), fl[j], j >= 3);
`ifdef ROUTER_DROP_CNT_EN
    chk("t4_drop_count", drop_count[15:0], 2);
`endif
    write_en = '0;
    run(8, -1, 0, 0, w0);
    select_out(3);
    chk("t4_fwd_count", sel.size(), 4);
    for (int k = 0; k < 4 && k < sel.size(); k++)
      chk($sformatf("t4_fwd_flit%0d", k), sel[k].f, pkt[0][k]);

    // reset mid-packet, then a fresh north-bound packet
    do_reset();
    load(0, 0);
    run(6, -1, 0, 0, w0);
    reset = 1'b1;
    write_en = '0;
    pend[0].delete();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_write_req", write_req, 0);
    chk("t5_idle_full", full, 0);
    select_out(3);
    chk("t5_pre_count", sel.size(), 5);
    for (int k = 0; k < 5 && k < sel.size(); k++)
      chk($sformatf("t5_pre_flit%0d", k), sel[k].f, pkt[0][k]);
    olog.delete();
    step();
    load(0, 2);
    run(14, -1, 0, 0, w0);
    expect_pkts("t5_north", 1, 2, -1, w0 + 2);
    chk("t5_total", olog.size(), FPP);

    // (1,1) -> local, (1,0) -> south, concurrently
    do_reset();
    load(3, 3);
    load(1, 4);
    run(14, -1, 0, 0, w0);
    expect_pkts("t6_local", 0, 3, -1, w0 + 2);
    expect_pkts("t6_south", 2, 4, -1, w0 + 2);
    chk("t6_total", olog.size(), 2 * FPP);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wormhole_router.md
WORMHOLE_ROUTER -- requirements
Module: wormhole_router

Interface
REQ-001 Parameters SHALL be:
  - FLIT_W, default 4, flit width in bits (even, >=4).
  - FLITS_PER_PKT, default 8, flits per packet (>=2).
  - FIFO_DEPTH, default 4, input buffer depth (power of 2, >=2).
  - X_COORDINATE, default 1, own X position.
  - Y_COORDINATE, default 1, own Y position.
REQ-002 Ports SHALL be as follows; port index i is 0 local, 1 north, 2 south, 3 east, 4 west:
  - clk  in  1  single router clock.
  - reset  in  1  synchronous, active-high.
  - in_flit  in  5*FLIT_W  incoming flit, port i at slice [i*FLIT_W +: FLIT_W].
  - write_en  in  5  write strobe per input.
  - full  out  5  input FIFO full per port.
  - out_flit  out  5*FLIT_W  outgoing flit per output.
  - write_req  out  5  outgoing flit valid per output.
  - dest_full  in  5  downstream full per output.
REQ-003 The design SHALL use one clock and a synchronous, active-high reset, named clk and reset.

Function
REQ-004 Each input SHALL own a FIFO_DEPTH-entry FIFO; write_en with full=0 SHALL push in_flit.
REQ-005 full SHALL be 1 exactly when the occupancy equals FIFO_DEPTH; write_en while full=1 SHALL drop the flit, even if a pop occurs in the same cycle.
REQ-006 A packet SHALL be FLITS_PER_PKT consecutive flits. Head flit [FLIT_W/2-1:0] is destination X; [FLIT_W-1:FLIT_W/2] is destination Y.
REQ-007 Routing SHALL be XY, decided from the head flit only:
  - dX>X gives east; dX<X gives west.
  - Otherwise dY>Y gives north; dY<Y gives south.
  - Otherwise local.
REQ-008 Each output SHALL have a round-robin arbiter over the inputs whose FIFO front is an unforwarded head routed to that output. Requests SHALL be masked while dest_full[o]=1.
REQ-009 On grant, the pointer SHALL move to one past the granted input; with no grant the pointer SHALL hold.
REQ-010 A grant SHALL lock output o to the input until that input's tail flit is forwarded. The lock SHALL be released at the end of the tail cycle, so the earliest new grant is the next cycle.
REQ-011 Each input SHALL keep a flit counter from 0 to FLITS_PER_PKT-1, incrementing per pop and wrapping to 0 after the tail.
REQ-012 A flit SHALL pop in the cycle in which all of the following hold: its FIFO is non-empty, it holds the lock (or is granted that cycle), and dest_full[o]=0.
REQ-013 out_flit and write_req SHALL be registered: a flit popped in cycle n appears in cycle n+1 with write_req=1 for exactly one cycle.
REQ-014 dest_full rising mid-packet SHALL stall the locked input with the lock retained; forwarding SHALL resume on the first cycle dest_full=0.
REQ-015 Inputs not granted SHALL hold their FIFO contents unchanged.
REQ-016 Sustained throughput SHALL be one flit per cycle per output.

Reset
REQ-017 reset SHALL clear:
  - all FIFOs (full=0);
  - flit counters, locks and arbiter pointers (pointer to port 0);
  - write_req=0 and out_flit=0.
REQ-018 Reset asserted mid-packet SHALL discard the partial packet. The first flit written after reset SHALL be treated as a head.

Configuration
REQ-019 With macro ROUTER_DROP_CNT_EN defined, a port drop_count (out, 5*16) SHALL be present. Each 16-bit counter SHALL increment on each REQ-005 drop, saturate at 16'hFFFF, and clear on reset.
REQ-020 Without ROUTER_DROP_CNT_EN, the drop_count port and its logic SHALL be absent and drops SHALL be silent.

Structure
REQ-021 Package router_pkg SHALL hold the port index constants (LOCAL=0 ... WEST=4), the direction typedef and the NUM_PORTS=5 constant.
REQ-022 The input buffer SHALL be a sub-module router_fifo (synchronous, parametrised width/depth), instantiated five times. Routing, arbitration and the crossbar SHALL stay in wormhole_router.

Verification
REQ-023 Local head dX=3,dY=1 at router (1,1), 8 flits, dest_full=0 -> east write_req high for 8 consecutive cycles starting 2 cycles after the first write_en; flits in order.
REQ-024 North and west heads both to east in the same cycle, pointer at 0 -> north wins, 8 flits; west's packet follows with no interleaving.
REQ-025 dest_full[east]=1 for 3 cycles after flit 3 -> flits 4..7 delayed by 3 cycles; lock held; no other input granted east.
REQ-026 FIFO_DEPTH=4, 6 writes with output blocked -> full=1 after the 4th write; 5th and 6th dropped; drop_count[port]=2 when the macro is defined.
REQ-027 reset for 1 cycle after flit 4 of 8 -> all outputs idle next cycle; a new 8-flit packet routes correctly.
REQ-028 Head dX=1,dY=1 -> local output; dX=1,dY=0 -> south output.
